uart_rx: RTL

- Serial-to-parallel UART receiver: 8 data bits, LSB first, one start bit (0), one stop bit (1), no parity, idle line high.
- Sits at the host-link boundary, opposite the team's transmitter. Default bit period matches the transmitter's 8192-clock bit time.
- Synchronizes the asynchronous serial input, validates the start bit at mid-bit, and samples every following bit at its centre.
- Presents each byte with a ready/clear handshake and a framing-error flag.

---
 rtl/uart_rx.sv | 132 +++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx -- serial-to-parallel UART receiver (8N1, LSB first, idle high).
//
// The asynchronous RX line is double-registered, a falling edge arms the
// receiver, the start bit is re-checked at its centre and each following bit
// is sampled at its centre. A completed byte is presented on rx_data with rdy
// set; frm_err reports a stop bit that read as 0.
//
// Parameters:
//   BAUD_CYCLES  clocks per bit (>= 4)
//   HALF_CYCLES  clocks from start detect to the start-bit centre sample
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   RX       in   asynchronous serial input, idles high
//   clr_rdy  in   one-clock pulse, clears rdy
//   rx_data  out  last received byte, held until the next frame completes
//   rdy      out  byte available in rx_data
//   frm_err  out  last completed frame had a 0 stop bit (valid while rdy)
module uart_rx #(
  parameter int BAUD_CYCLES = 8192,
  parameter int HALF_CYCLES = BAUD_CYCLES / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err
);

  localparam int TW = $clog2(BAUD_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic          rx_ff1_q, rx_ff2_q, rx_prev_q;
  logic          start_det;
  logic          samp_tick;
  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic [3:0]    bitcnt_q;
  logic [7:0]    shift_q;
  logic [7:0]    rx_data_q;
  logic          rdy_q;
  logic          frm_err_q;

  assign start_det = rx_prev_q & ~rx_ff2_q;
  // The sample edge is the one on which the count reaches 0, so a load of N
  // puts the next sample exactly N edges later.
  assign samp_tick = (timer_q == TW'(1));

  assign rx_data = rx_data_q;
  assign rdy     = rdy_q;
  assign frm_err = frm_err_q;

  // Synchronizer and edge-detect flops; reset to the idle (high) level so
  // that reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1_q  <= 1'b1;
      rx_ff2_q  <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_ff1_q  <= RX;
      rx_ff2_q  <= rx_ff1_q;
      rx_prev_q <= rx_ff2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bitcnt_q  <= '0;
      shift_q   <= '0;
      rx_data_q <= 8'h00;
      rdy_q     <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      // Consumer clear first; the STOP-state set below overrides it.
      if (clr_rdy) rdy_q <= 1'b0;

      if (state_q != IDLE && !samp_tick && timer_q != '0)
        timer_q <= timer_q - TW'(1);

      case (state_q)
        IDLE: begin
          if (start_det) begin
            state_q   <= START;
            timer_q   <= TW'(HALF_CYCLES);
            // A new frame discards any unread byte's ready status.
            rdy_q     <= 1'b0;
            frm_err_q <= 1'b0;
          end
        end
        START: begin
          if (samp_tick) begin
            if (rx_ff2_q) begin
              // Line back high at mid start bit: glitch, not a frame.
              state_q <= IDLE;
              timer_q <= '0;
            end else begin
              state_q  <= DATA;
              timer_q  <= TW'(BAUD_CYCLES);
              bitcnt_q <= '0;
            end
          end
        end
        DATA: begin
          if (samp_tick) begin
            shift_q  <= {rx_ff2_q, shift_q[7:1]};
            bitcnt_q <= bitcnt_q + 4'd1;
            timer_q  <= TW'(BAUD_CYCLES);
            if (bitcnt_q == 4'd7) state_q <= STOP;
          end
        end
        STOP: begin
          if (samp_tick) begin
            rx_data_q <= shift_q;
            rdy_q     <= 1'b1;
            frm_err_q <= ~rx_ff2_q;
            state_q   <= IDLE;
            timer_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
